mem_wb_writeback: RTL and testbench
===================================

// Module: mem_wb_writeback
// PURPOSE
// - MEM/WB pipeline register plus writeback select; sits directly upstream of the register bank.
// - Captures the retiring instruction and selects its result: ALU, load data or PC+4.
// - Drives the bank write port (ENA_WRITE/WRITE_REG/WRITE_DATA) and a forwarding tap for EX.
// - Keeps a 64-bit retired-instruction counter.
// PARAMETERS
// - DATA_W      32  datapath / register width
// - REG_AW      5   register address width (32 registers)
// - CNT_W       64  retired-instruction counter width
// PORTS
// - CLK           in   1       single clock, rising edge
// - aRST          in   1       asynchronous reset, active-high
// - in_valid      in   1       MEM stage presents a valid instruction
// - stall         in   1       hold stage contents this cycle
// - flush         in   1       kill stage contents this cycle
// - reg_write_i   in   1       instruction writes rd
// - rd_i          in   REG_AW  destination register
// - wb_sel_i      in   2       00 ALU, 01 LOAD, 10 PC+4, 11 reserved (treated as ALU)
// - funct3_i      in   3       load type: 000 LB,001 LH,010 LW,100 LBU,101 LHU
// - alu_result_i  in   DATA_W  ALU result; [1:0] is the load byte offset
// - mem_rdata_i   in   DATA_W  raw aligned 32-bit word from data memory
// - pc_plus4_i    in   DATA_W  PC+4 of the instruction
// - ENA_WRITE     out  1       bank write enable
// - WRITE_REG     out  REG_AW  bank write address
// - WRITE_DATA    out  DATA_W  bank write data
// - fwd_valid     out  1       forwarding tap valid (rd!=0, writes)
// - fwd_rd        out  REG_AW  forwarding register
// - fwd_data      out  DATA_W  forwarding value (= WRITE_DATA)
// - misalign      out  1       registered: held load is misaligned
// - instret       out  CNT_W   retired-instruction count
// BEHAVIOUR
// - Reset (aRST=1, any time, async): valid_q=0, written_q=0, all data/addr regs 0, instret=0.
//   ENA_WRITE=0, WRITE_REG=0, WRITE_DATA=0, fwd_valid=0, misalign=0. A reset mid-stall drops the entry.
// - Capture priority per posedge: flush > stall > load.
//   - flush=1: valid_q<=0 (even if stall=1).
//   - stall=1: hold all regs.
//   - otherwise: valid_q<=in_valid; data regs load; written_q<=0.
// - Result select is combinational before the register, giving 1-cycle latency:
//   value shows on WRITE_DATA the cycle after capture.
// - Load extraction, off = alu_result_i[1:0]:
//   - LB/LBU: byte off, sign-/zero-extend.
//   - LH/LHU: half off[1], sign-/zero-extend.
//   - LW: whole word.
//   - Undefined funct3: whole word.
// - Misaligned load = wb_sel LOAD and ((LH/LHU and off[0]) or (LW and off!=0)).
//   It is latched into misalign; that entry never writes.
// - ENA_WRITE = valid_q & reg_write_q & rd_q!=0 & !misalign & !written_q.
//   written_q sets after the first ENA_WRITE cycle, so a stalled entry writes exactly once.
// - x0 is never written. fwd_valid ignores written_q: the tap stays valid while the entry is held.
// - instret += 1 on each posedge that captures in_valid=1 with stall=0, flush=0.
//   It wraps modulo 2^CNT_W. Misaligned loads still count.
// STRUCTURE
// - Shared package: wb_sel_t enum (WB_ALU, WB_LOAD, WB_PC4); load funct3 constants; DATA_W/REG_AW.
// - Sub-module load_extract: combinational (word, off, funct3) -> (data, misalign).
// TESTING
// - Reset:
//   - aRST pulse mid-run -> all outputs 0 immediately (before next edge), instret=0.
// - ALU write:
//   - rd=5, ALU 0x1234_5678 -> next cycle ENA_WRITE=1, WRITE_REG=5, WRITE_DATA=0x12345678.
//   - Same with rd=0 -> ENA_WRITE=0.
// - Load extract:
//   - mem_rdata 0x80FF_7F01, LB off=3 -> 0xFFFFFF80.
//   - LBU off=2 -> 0x000000FF.
//   - LH off=2 -> 0xFFFF80FF.
//   - LHU off=0 -> 0x00007F01.
//   - LH off=1 -> misalign=1, ENA_WRITE=0.
// - Stall:
//   - capture rd=7, then stall 3 cycles -> ENA_WRITE high exactly 1 cycle.
//   - fwd_valid high all 4 cycles; instret +1.
// - Flush vs stall:
//   - flush=1 with stall=1 while holding rd=9 -> next cycle fwd_valid=0, ENA_WRITE=0.
//   - instret unchanged.
// - PC+4 / counter:
//   - JAL rd=1, pc_plus4=0x0000_0104 -> WRITE_DATA=0x104.
//   - 40 back-to-back valid captures -> instret=40.

Source files
------------

// File: rtl/mem_wb_writeback_pkg.sv
// Shared types and constants for the MEM/WB writeback slice.
package mem_wb_writeback_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 64;

    // Writeback source select; encoding 2'b11 is reserved and handled as ALU.
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_t;

    // Load-type encodings carried on funct3.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_writeback_if.sv
// MEM-stage inputs and bank/forwarding outputs of the writeback stage.
// Handshake: there is no ready; an entry is accepted on any rising edge where
// in_valid=1 and neither stall nor flush is asserted. ENA_WRITE and fwd_valid
// qualify the bank write port and the forwarding tap respectively.
interface mem_wb_writeback_if;
    import mem_wb_writeback_pkg::*;

    logic              in_valid;
    logic              stall;
    logic              flush;
    logic              reg_write_i;
    logic [REG_AW-1:0] rd_i;
    logic [1:0]        wb_sel_i;
    logic [2:0]        funct3_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [DATA_W-1:0] pc_plus4_i;

    logic              ENA_WRITE;
    logic [REG_AW-1:0] WRITE_REG;
    logic [DATA_W-1:0] WRITE_DATA;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic              misalign;
    logic [CNT_W-1:0]  instret;

    // Driver side (MEM stage / testbench).
    modport master (
        output in_valid, stall, flush, reg_write_i, rd_i, wb_sel_i, funct3_i,
               alu_result_i, mem_rdata_i, pc_plus4_i,
        input  ENA_WRITE, WRITE_REG, WRITE_DATA, fwd_valid, fwd_rd, fwd_data,
               misalign, instret
    );

    // Writeback stage side.
    modport slave (
        input  in_valid, stall, flush, reg_write_i, rd_i, wb_sel_i, funct3_i,
               alu_result_i, mem_rdata_i, pc_plus4_i,
        output ENA_WRITE, WRITE_REG, WRITE_DATA, fwd_valid, fwd_rd, fwd_data,
               misalign, instret
    );

endinterface

// File: rtl/mem_wb_writeback_load_extract.sv
// Combinational load data extraction: picks the byte/half addressed by off,
// sign- or zero-extends it and flags misaligned halfword/word accesses.
module mem_wb_writeback_load_extract
    import mem_wb_writeback_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select, extension and alignment check for the addressed load.
    always_comb begin
        byte_v   = word[{off, 3'b000} +: 8];
        half_v   = off[1] ? word[31:16] : word[15:0];
        data     = word;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_v[7]}}, byte_v};
            F3_LBU: data = {24'h0, byte_v};
            F3_LH: begin
                data     = {{16{half_v[15]}}, half_v};
                misalign = off[0];
            end
            F3_LHU: begin
                data     = {16'h0, half_v};
                misalign = off[0];
            end
            F3_LW:  misalign = (off != 2'b00);
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with writeback source select, bank write port,
// EX forwarding tap and retired-instruction counter.
module mem_wb_writeback
    import mem_wb_writeback_pkg::*;
(
    input  logic              CLK,
    input  logic              aRST,
    mem_wb_writeback_if.slave bus
);

    logic              valid_q;
    logic              written_q;
    logic              reg_write_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              misalign_q;
    logic [CNT_W-1:0]  instret_q;

    logic [DATA_W-1:0] load_data;
    logic              load_misalign;
    logic [DATA_W-1:0] wb_data_d;
    logic              misalign_d;
    logic              is_load;
    logic              ena_write;
    logic              capture;

    mem_wb_writeback_load_extract u_load_extract (
        .word     (bus.mem_rdata_i),
        .off      (bus.alu_result_i[1:0]),
        .funct3   (bus.funct3_i),
        .data     (load_data),
        .misalign (load_misalign)
    );

    // Result select ahead of the register so the value appears one cycle after capture.
    always_comb begin
        is_load    = (bus.wb_sel_i == WB_LOAD);
        misalign_d = is_load & load_misalign;
        case (bus.wb_sel_i)
            WB_LOAD: wb_data_d = load_data;
            WB_PC4:  wb_data_d = bus.pc_plus4_i;
            default: wb_data_d = bus.alu_result_i;
        endcase
        capture = bus.in_valid & ~bus.stall & ~bus.flush;
    end

    // Write once per entry: written_q suppresses repeats while a stall holds it.
    always_comb begin
        ena_write = valid_q & reg_write_q & (rd_q != '0) & ~misalign_q & ~written_q;
    end

    // Stage register; flush beats stall, stall beats a fresh load.
    always_ff @(posedge CLK or posedge aRST) begin
        if (aRST) begin
            valid_q     <= 1'b0;
            written_q   <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wb_data_q   <= '0;
            misalign_q  <= 1'b0;
        end else if (bus.flush) begin
            valid_q   <= 1'b0;
            written_q <= 1'b0;
        end else if (bus.stall) begin
            written_q <= written_q | ena_write;
        end else begin
            valid_q     <= bus.in_valid;
            written_q   <= 1'b0;
            reg_write_q <= bus.reg_write_i;
            rd_q        <= bus.rd_i;
            wb_data_q   <= wb_data_d;
            misalign_q  <= misalign_d;
        end
    end

    // Retired-instruction counter, wraps naturally; misaligned loads still count.
    always_ff @(posedge CLK or posedge aRST) begin
        if (aRST) begin
            instret_q <= '0;
        end else if (capture) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Output drive; the forwarding tap stays valid for the whole hold.
    always_comb begin
        bus.ENA_WRITE  = ena_write;
        bus.WRITE_REG  = rd_q;
        bus.WRITE_DATA = wb_data_q;
        bus.fwd_valid  = valid_q & reg_write_q & (rd_q != '0) & ~misalign_q;
        bus.fwd_rd     = rd_q;
        bus.fwd_data   = wb_data_q;
        bus.misalign   = valid_q & misalign_q;
        bus.instret    = instret_q;
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: the driver pushes expected bank writes
// into a queue, a monitor pops and compares on every ENA_WRITE cycle.
module tb_mem_wb_writeback;
    import mem_wb_writeback_pkg::*;

    localparam int W = REG_AW + DATA_W;

    logic CLK;
    logic aRST;

    mem_wb_writeback_if bus ();

    mem_wb_writeback dut (
        .CLK  (CLK),
        .aRST (aRST),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [W-1:0]     exp_q[$];
    logic [CNT_W-1:0] exp_cnt;

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always begin
        @(posedge CLK);
        #1;
        if (bus.ENA_WRITE === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got reg %0d data 0x%08h expected no write",
                         bus.WRITE_REG, bus.WRITE_DATA);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("write_reg",  64'(bus.WRITE_REG),  64'(e[W-1:DATA_W]));
                check("write_data", 64'(bus.WRITE_DATA), 64'(e[DATA_W-1:0]));
                check("fwd_data",   64'(bus.fwd_data),   64'(e[DATA_W-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic drive(input logic valid_v, input logic stall_v, input logic flush_v,
                         input logic rw, input logic [REG_AW-1:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [DATA_W-1:0] alu,
                         input logic [DATA_W-1:0] mem, input logic [DATA_W-1:0] pc4);
        bus.in_valid     = valid_v;
        bus.stall        = stall_v;
        bus.flush        = flush_v;
        bus.reg_write_i  = rw;
        bus.rd_i         = rd;
        bus.wb_sel_i     = sel;
        bus.funct3_i     = f3;
        bus.alu_result_i = alu;
        bus.mem_rdata_i  = mem;
        bus.pc_plus4_i   = pc4;
        if (valid_v && !stall_v && !flush_v) exp_cnt = exp_cnt + 64'd1;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 3'b000, '0, '0, '0);
    endtask

    task automatic drive_alu(input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] v);
        drive(1'b1, 1'b0, 1'b0, 1'b1, rd, WB_ALU, 3'b000, v, 32'h5555_5555, 32'hAAAA_AAAA);
    endtask

    task automatic drive_load(input logic [REG_AW-1:0] rd, input logic [2:0] f3,
                              input logic [1:0] off, input logic [DATA_W-1:0] word);
        drive(1'b1, 1'b0, 1'b0, 1'b1, rd, WB_LOAD, f3, {28'h0000_100, 2'b00, off}, word,
              32'h0000_0F00);
    endtask

    task automatic expect_write(input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] d);
        exp_q.push_back({rd, d});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        aRST    = 1'b1;
        exp_cnt = '0;
        drive_idle();
        exp_cnt = '0;
        repeat (2) tick();
        aRST = 1'b0;

        // Reset state
        tick();
        check("rst_ena_write",  64'(bus.ENA_WRITE),  64'd0);
        check("rst_write_reg",  64'(bus.WRITE_REG),  64'd0);
        check("rst_write_data", 64'(bus.WRITE_DATA), 64'd0);
        check("rst_fwd_valid",  64'(bus.fwd_valid),  64'd0);
        check("rst_misalign",   64'(bus.misalign),   64'd0);
        check("rst_instret",    bus.instret,         64'd0);

        // ALU write to rd=5
        drive_alu(5'd5, 32'h1234_5678);
        expect_write(5'd5, 32'h1234_5678);
        tick();
        drive_idle();
        check("alu_fwd_valid", 64'(bus.fwd_valid), 64'd1);
        check("alu_fwd_rd",    64'(bus.fwd_rd),    64'd5);
        check("alu_instret",   bus.instret,        64'd1);

        // ALU write to x0 must not reach the bank
        tick();
        drive_alu(5'd0, 32'h1234_5678);
        tick();
        drive_idle();
        check("x0_ena_write", 64'(bus.ENA_WRITE), 64'd0);
        check("x0_fwd_valid", 64'(bus.fwd_valid), 64'd0);

        // Load extraction, back to back, word 0x80FF_7F01
        tick();
        drive_load(5'd10, F3_LB,  2'd3, 32'h80FF_7F01); expect_write(5'd10, 32'hFFFF_FF80);
        tick();
        drive_load(5'd11, F3_LBU, 2'd2, 32'h80FF_7F01); expect_write(5'd11, 32'h0000_00FF);
        tick();
        drive_load(5'd12, F3_LH,  2'd2, 32'h80FF_7F01); expect_write(5'd12, 32'hFFFF_80FF);
        tick();
        drive_load(5'd13, F3_LHU, 2'd0, 32'h80FF_7F01); expect_write(5'd13, 32'h0000_7F01);
        tick();
        drive_load(5'd14, F3_LB,  2'd1, 32'h80FF_7F01); expect_write(5'd14, 32'h0000_007F);
        tick();
        drive_load(5'd15, F3_LW,  2'd0, 32'h80FF_7F01); expect_write(5'd15, 32'h80FF_7F01);
        tick();
        drive_load(5'd16, 3'b011, 2'd0, 32'h80FF_7F01); expect_write(5'd16, 32'h80FF_7F01);

        // Misaligned LH off=1: counted, flagged, never written
        tick();
        drive_load(5'd17, F3_LH, 2'd1, 32'h80FF_7F01);
        tick();
        drive_idle();
        check("lh_mis_misalign",  64'(bus.misalign),  64'd1);
        check("lh_mis_ena_write", 64'(bus.ENA_WRITE), 64'd0);
        check("lh_mis_instret",   bus.instret,        exp_cnt);

        // Misaligned LW off=2
        tick();
        drive_load(5'd18, F3_LW, 2'd2, 32'h80FF_7F01);
        tick();
        drive_idle();
        check("lw_mis_misalign", 64'(bus.misalign), 64'd1);
        check("lw_mis_fwd",      64'(bus.fwd_valid), 64'd0);

        // Stall: capture rd=7 then hold it for three cycles
        tick();
        drive_alu(5'd7, 32'hCAFE_0007);
        expect_write(5'd7, 32'hCAFE_0007);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stall_fwd_valid", 64'(bus.fwd_valid), 64'd1);
            check("stall_fwd_rd",    64'(bus.fwd_rd),    64'd7);
            if (k < 3)
                drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, WB_ALU, 3'b000, 32'hBAD0_0008, '0, '0);
            else
                drive_idle();
        end
        check("stall_instret", bus.instret, exp_cnt);

        // Flush wins over stall while holding rd=9
        tick();
        drive_alu(5'd9, 32'h0000_0909);
        expect_write(5'd9, 32'h0000_0909);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd20, WB_ALU, 3'b000, 32'hBAD0_0020, '0, '0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd21, WB_ALU, 3'b000, 32'hBAD0_0021, '0, '0);
        tick();
        drive_idle();
        check("flush_fwd_valid", 64'(bus.fwd_valid), 64'd0);
        check("flush_ena_write", 64'(bus.ENA_WRITE), 64'd0);
        check("flush_instret",   bus.instret,        exp_cnt);

        // JAL rd=1: PC+4 select
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, WB_PC4, 3'b000, 32'hDEAD_BEEF, 32'h1111_1111,
              32'h0000_0104);
        expect_write(5'd1, 32'h0000_0104);
        // Reserved select behaves as ALU
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 2'b11, 3'b000, 32'h0A1B_2C3D, 32'h1111_1111,
              32'h0000_0200);
        expect_write(5'd2, 32'h0A1B_2C3D);
        tick();
        drive_idle();
        tick();
        check("drain_before_reset", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset mid-run while an entry is writing
        drive_alu(5'd3, 32'hDEAD_0003);
        expect_write(5'd3, 32'hDEAD_0003);
        @(posedge CLK);
        #3;
        aRST = 1'b1;
        #1;
        check("arst_ena_write",  64'(bus.ENA_WRITE),  64'd0);
        check("arst_write_reg",  64'(bus.WRITE_REG),  64'd0);
        check("arst_write_data", 64'(bus.WRITE_DATA), 64'd0);
        check("arst_fwd_valid",  64'(bus.fwd_valid),  64'd0);
        check("arst_instret",    bus.instret,         64'd0);
        exp_cnt = '0;
        tick();
        drive_idle();
        aRST = 1'b0;

        // 40 back-to-back captures
        for (int i = 0; i < 40; i++) begin
            tick();
            drive_alu(5'((i % 31) + 1), 32'h1000_0000 + 32'(i));
            expect_write(5'((i % 31) + 1), 32'h1000_0000 + 32'(i));
        end
        tick();
        drive_idle();
        check("instret_40", bus.instret, 64'd40);
        repeat (3) tick();
        check("drain_final", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
